ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
Two-requester arbiter that shares the single-port data RAM (512 x data_w, synchronous read) between the matrix-multiply control unit (requester 0) and a host loader/unloader (requester 1).
- Grants at most one access per cycle.
- Round-robin between requesters, with a bounded lock for block bursts.
- Generates per-requester read-valid strobes aligned to the RAM's 1-cycle read latency.
- Sits between the requesters and the RAM instance in the multiplier top level.

Parameters:
data_w, 32, RAM word width
addr_w, 9, RAM address width (512 words)
max_burst, 8, max consecutive locked grants to one requester while the other is waiting

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req0  in  1  requester 0 (control unit) access request
lock0  in  1  requester 0 wants to keep ownership for consecutive accesses
we0  in  1  requester 0 write enable (1=write, 0=read)
addr0  in  addr_w  requester 0 address
wdata0  in  data_w  requester 0 write data
gnt0  out  1  requester 0 access issued this cycle
rvalid0  out  1  read data for requester 0 valid on rdata this cycle
req1, lock1, we1, addr1, wdata1, gnt1, rvalid1  same widths/meaning for requester 1 (host)
rdata  out  data_w  RAM read data, shared; qualified by rvalid0/rvalid1
ram_addr  out  addr_w  to RAM address
ram_we  out  1  to RAM write enable
ram_w_data  out  data_w  to RAM write data
ram_r_data  in  data_w  from RAM read data (valid 1 cycle after a read address)

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state updates on the rising edge of clk.
- State: last_winner (1 bit), owner_valid, burst_cnt (ceil(log2(max_burst+1)) bits), rvalid0_q, rvalid1_q.
- Reset values:
  - last_winner=1, so requester 0 wins the first tie.
  - owner_valid=0, burst_cnt=0, rvalid0=rvalid1=0.
  - While rst=1: gnt0=gnt1=0, ram_we=0, ram_addr=0, ram_w_data=0.
- Grant is combinational in the same cycle from req*, lock* and state. The requester holds req/we/addr/wdata stable until it sees gnt.
- Selection, in priority order:
  1. No req: no grant; ram_we=0, ram_addr=0, ram_w_data=0.
  2. Exactly one req: that requester is granted.
  3. Both req, owner_valid=1, and the owner's lock=1: if burst_cnt<max_burst, the owner is granted; otherwise the non-owner is granted (forced rotation).
  4. Both req, no valid lock: the requester != last_winner is granted.
- RAM drive: ram_addr/ram_we/ram_w_data = winner's addr/we/wdata. Exactly one gnt is high per granted cycle; gnt0 and gnt1 are never both 1.
- Update on a grant to requester k:
  - last_winner<=k.
  - If lock_k=1: if owner_valid=1 and owner==k, burst_cnt<=burst_cnt+1; otherwise burst_cnt<=1, owner<=k, owner_valid<=1.
  - If lock_k=0: owner_valid<=0, burst_cnt<=0.
  - burst_cnt saturates at max_burst.
- Owner drops req or lock without a grant: owner_valid<=0, burst_cnt<=0.
- Uncontended locked bursts are unbounded. The counter saturates; the cap only applies when the other requester is waiting.
- Read return: rvalidk <= gnt_k & ~we_k, registered. rdata = ram_r_data, passed through. Read latency is gnt to rvalid = 1 cycle.
- Write followed by a read of the same address on the next grant returns the new data. This relies on RAM write-first/synchronous behaviour; the arbiter adds no forwarding.
- Back-to-back reads by the same requester are allowed every cycle. rvalid can be high on consecutive cycles.
- rst asserted mid-burst: all state clears at that edge. An rvalid pending from the cycle before rst is dropped, i.e. rvalid=0 in the cycle after the rst edge.
- Starvation bound: a waiting requester is granted within max_burst+1 cycles of asserting req.

Test Plan:
1. Reset, then req0=1, we0=0, addr0=5 (mem[5]=0xDEADBEEF) -> gnt0=1 same cycle, ram_addr=5, ram_we=0; next cycle rvalid0=1, rdata=0xDEADBEEF, rvalid1=0.
2. req0 and req1 held high, no locks, 6 cycles -> grants alternate 0,1,0,1,0,1 (requester 0 first after reset); never both gnt high.
3. req1 write addr=10 data=0x12345678, then req0 read addr=10 next cycle -> gnt1 then gnt0; rvalid0 with rdata=0x12345678.
4. req0+lock0 high, req1 high throughout, max_burst=8 -> gnt0 for 8 consecutive cycles, gnt1 on the 9th, then gnt0 again (lock re-acquired, burst_cnt=1).
5. req0+lock0 alone for 20 cycles -> gnt0 every cycle (uncapped); req1 asserted at cycle 20 -> gnt1 within 9 cycles.
6. Read granted at cycle N, rst=1 at cycle N+1 -> rvalid0=0 at N+1 and N+2, outputs at reset values; after rst drops, a simultaneous req0/req1 grants requester 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two requesters,
// with bounded lock bursts and read-valid strobes aligned to the RAM's 1-cycle latency.
module ram_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              lock0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              lock1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_r_data
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic             r_last_winner;
    logic             r_owner;
    logic             r_owner_valid;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_rvalid0;
    logic             r_rvalid1;

    logic w_gnt0;
    logic w_gnt1;
    logic w_win;
    logic w_owner_lock;
    logic w_win_lock;

    // Grant decision: single requester wins outright; contention honours a live lock
    // until the burst cap, otherwise alternates away from the last winner.
    always_comb begin
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_win        = 1'b0;
        w_owner_lock = r_owner ? lock1 : lock0;
        if (!rst) begin
            if (req0 && !req1) begin
                w_gnt0 = 1'b1;
            end else if (req1 && !req0) begin
                w_gnt1 = 1'b1;
            end else if (req0 && req1) begin
                if (r_owner_valid && w_owner_lock) begin
                    w_win = (r_burst_cnt < CNT_MAX) ? r_owner : ~r_owner;
                end else begin
                    w_win = ~r_last_winner;
                end
                w_gnt0 = ~w_win;
                w_gnt1 = w_win;
            end
        end
    end

    assign w_win_lock = w_gnt1 ? lock1 : lock0;

    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign ram_addr   = w_gnt1 ? addr1  : (w_gnt0 ? addr0  : '0);
    assign ram_we     = w_gnt1 ? we1    : (w_gnt0 ? we0    : 1'b0);
    assign ram_w_data = w_gnt1 ? wdata1 : (w_gnt0 ? wdata0 : '0);

    // Masking with rst drops a read return that would land during reset.
    assign rvalid0 = r_rvalid0 & ~rst;
    assign rvalid1 = r_rvalid1 & ~rst;
    assign rdata   = ram_r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_winner <= 1'b1;
            r_owner       <= 1'b0;
            r_owner_valid <= 1'b0;
            r_burst_cnt   <= '0;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~we0;
            r_rvalid1 <= w_gnt1 & ~we1;
            if (w_gnt0 || w_gnt1) begin
                r_last_winner <= w_gnt1;
                if (w_win_lock) begin
                    if (r_owner_valid && (r_owner == w_gnt1)) begin
                        if (r_burst_cnt < CNT_MAX) begin
                            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_owner       <= w_gnt1;
                        r_owner_valid <= 1'b1;
                        r_burst_cnt   <= CNT_W'(1);
                    end
                end else begin
                    r_owner_valid <= 1'b0;
                    r_burst_cnt   <= '0;
                end
            end else begin
                // No grant means nobody is requesting, so any lock has been released.
                r_owner_valid <= 1'b0;
                r_burst_cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized
// requester traffic compared cycle by cycle against a behavioural arbitration model.
module tb_ram_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 9;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, lock0, we0, req1, lock1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata, ram_w_data, ram_r_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic          ld_en;

    always #5 clk = ~clk;

    ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 5) ? 32'hDEADBEEF : (32'(i) * 32'h01010101) ^ 32'hA5A50000;
    endfunction

    logic [DW-1:0] mem [0:511];
    always @(posedge clk) begin
        if (ld_en) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_w_data;
        end
        ram_r_data <= mem[ram_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model: arbitration rules in terms of owner, streak length and memory contents.
    bit            m_last = 1'b1, m_own = 1'b0, m_ownv = 1'b0, m_rv0 = 1'b0, m_rv1 = 1'b0;
    int            m_cnt = 0;
    logic [DW-1:0] m_rd = '0;
    logic [DW-1:0] m_mem [0:511];

    bit            s_g0, s_g1, s_rv0, s_rv1;
    logic [DW-1:0] s_rd;
    logic [AW-1:0] s_addr;

    task automatic step();
        bit e0, e1, win, k, lk, ewe;
        logic [31:0] ea, ew;
        @(negedge clk);
        e0 = 0; e1 = 0; win = 0;
        if (!rst) begin
            if (req0 && !req1) e0 = 1;
            else if (req1 && !req0) e1 = 1;
            else if (req0 && req1) begin
                if (m_ownv && (m_own ? lock1 : lock0)) win = (m_cnt < MB) ? m_own : !m_own;
                else win = !m_last;
                e0 = !win; e1 = win;
            end
        end
        ea  = e1 ? 32'(addr1) : (e0 ? 32'(addr0) : 32'd0);
        ew  = e1 ? wdata1 : (e0 ? wdata0 : 32'd0);
        ewe = e1 ? we1 : (e0 ? we0 : 1'b0);
        check_val("gnt0", 32'(gnt0), 32'(e0));
        check_val("gnt1", 32'(gnt1), 32'(e1));
        check_val("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
        check_val("ram_addr", 32'(ram_addr), ea);
        check_val("ram_we", 32'(ram_we), 32'(ewe));
        check_val("ram_w_data", ram_w_data, ew);
        check_val("rvalid0", 32'(rvalid0), 32'(m_rv0 && !rst));
        check_val("rvalid1", 32'(rvalid1), 32'(m_rv1 && !rst));
        if (!rst && (m_rv0 || m_rv1)) check_val("rdata", rdata, m_rd);
        s_g0 = gnt0; s_g1 = gnt1; s_rv0 = rvalid0; s_rv1 = rvalid1; s_rd = rdata; s_addr = ram_addr;
        if (rst) begin
            m_last = 1; m_ownv = 0; m_cnt = 0; m_rv0 = 0; m_rv1 = 0;
        end else begin
            m_rv0 = e0 && !we0;
            m_rv1 = e1 && !we1;
            if (e0 || e1) begin
                k  = e1;
                lk = e1 ? lock1 : lock0;
                if (ewe) m_mem[ea[AW-1:0]] = ew;
                else m_rd = m_mem[ea[AW-1:0]];
                m_last = k;
                if (lk) begin
                    if (m_ownv && m_own == k) m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
                    else begin m_own = k; m_ownv = 1; m_cnt = 1; end
                end else begin
                    m_ownv = 0; m_cnt = 0;
                end
            end else begin
                m_ownv = 0; m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input bit r, input bit l, input bit w, input int a, input logic [31:0] d);
        req0 = r; lock0 = l; we0 = w; addr0 = AW'(a); wdata0 = d;
    endtask

    task automatic set1(input bit r, input bit l, input bit w, input int a, input logic [31:0] d);
        req1 = r; lock1 = l; we1 = w; addr1 = AW'(a); wdata1 = d;
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    bit pend0 = 0, pend1 = 0, found;
    int w0 = 0, w1 = 0;

    initial begin
        for (int i = 0; i < 512; i++) m_mem[i] = init_word(i);
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
        rst = 1; ld_en = 1;
        step();
        check_val("rst_gnt0", 32'(s_g0), 32'd0);
        check_val("rst_rvalid0", 32'(s_rv0), 32'd0);
        rst = 0; ld_en = 0;

        // Simple read of a preloaded word.
        set0(1, 0, 0, 5, 0); step();
        check_val("t1_gnt0", 32'(s_g0), 32'd1);
        check_val("t1_addr", 32'(s_addr), 32'd5);
        set0(0, 0, 0, 0, 0); step();
        check_val("t1_rvalid0", 32'(s_rv0), 32'd1);
        check_val("t1_rdata", s_rd, 32'hDEADBEEF);
        check_val("t1_rvalid1", 32'(s_rv1), 32'd0);

        // Contended unlocked requests alternate, requester 0 first.
        do_reset();
        set0(1, 0, 0, 1, 0); set1(1, 0, 0, 2, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("t2_gnt0", 32'(s_g0), 32'((i % 2) == 0));
            check_val("t2_gnt1", 32'(s_g1), 32'((i % 2) == 1));
        end

        // Write by host then read back by control unit.
        set0(0, 0, 0, 0, 0); set1(1, 0, 1, 10, 32'h12345678); step();
        check_val("t3_gnt1", 32'(s_g1), 32'd1);
        set1(0, 0, 0, 0, 0); set0(1, 0, 0, 10, 0); step();
        check_val("t3_gnt0", 32'(s_g0), 32'd1);
        set0(0, 0, 0, 0, 0); step();
        check_val("t3_rvalid0", 32'(s_rv0), 32'd1);
        check_val("t3_rdata", s_rd, 32'h12345678);

        // Locked burst capped while the host waits.
        do_reset();
        set0(1, 1, 0, 3, 0); set1(1, 0, 0, 4, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("t4_gnt0", 32'(s_g0), 32'(i != 8));
            check_val("t4_gnt1", 32'(s_g1), 32'(i == 8));
        end

        // Uncontended locked burst is unbounded; host still gets in promptly.
        do_reset();
        set1(0, 0, 0, 0, 0); set0(1, 1, 0, 6, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check_val("t5_gnt0", 32'(s_g0), 32'd1);
        end
        set1(1, 0, 0, 8, 0);
        found = 0;
        for (int i = 0; i < MB + 1 && !found; i++) begin
            step();
            if (s_g1) found = 1;
        end
        check_val("t5_gnt1_within_bound", 32'(found), 32'd1);

        // Reset right after a read grant drops the return.
        do_reset();
        set1(0, 0, 0, 0, 0); set0(1, 0, 0, 7, 0); step();
        check_val("t6_gnt0", 32'(s_g0), 32'd1);
        set0(0, 0, 0, 0, 0); rst = 1; step();
        check_val("t6_rvalid0_rst", 32'(s_rv0), 32'd0);
        rst = 0; step();
        check_val("t6_rvalid0_after", 32'(s_rv0), 32'd0);
        set0(1, 0, 0, 1, 0); set1(1, 0, 0, 2, 0); step();
        check_val("t6_tie_gnt0", 32'(s_g0), 32'd1);

        // Randomized traffic with occasional resets.
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!pend0 && $urandom_range(0, 3) != 0) begin
                pend0 = 1;
                set0(1, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
            end
            if (!pend1 && $urandom_range(0, 2) == 0) begin
                pend1 = 1;
                set1(1, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
            end
            req0 = pend0; req1 = pend1;
            lock0 = ($urandom_range(0, 3) != 0);
            lock1 = ($urandom_range(0, 2) == 0);
            step();
            if (rst) begin
                w0 = 0; w1 = 0;
            end else begin
                if (req0) begin
                    w0++;
                    if (s_g0) begin
                        check_val("starve0", 32'(w0 <= MB + 1), 32'd1);
                        w0 = 0; pend0 = 0;
                    end
                end
                if (req1) begin
                    w1++;
                    if (s_g1) begin
                        check_val("starve1", 32'(w1 <= MB + 1), 32'd1);
                        w1 = 0; pend1 = 0;
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
